// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter over two line buffers; one output per input, registered 1 cycle after the accepting edge.
// Valid/ready on both sides: input stalls while the output slot is full or while the last WIDTH_P+1 outputs drain.
module sobel_stream #(
  parameter int PIXEL_WIDTH_P = 8,
  parameter int WIDTH_P       = 10,
  parameter int HEIGHT_P      = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [PIXEL_WIDTH_P-1:0] pixel_i,
  input  logic                     mode_i,
  input  logic [PIXEL_WIDTH_P+2:0] thresh_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PIXEL_WIDTH_P-1:0] pixel_o,
  output logic                     last_o
);

  localparam int PW = PIXEL_WIDTH_P;
  localparam int MW = PIXEL_WIDTH_P + 3;
  localparam int CW = $clog2(WIDTH_P);
  localparam int RW = $clog2(HEIGHT_P);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
  } col_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   in_col_q, out_col_q;
  logic [RW-1:0]   in_row_q, out_row_q;
  logic [PW-1:0]   lb0_q [WIDTH_P];
  logic [PW-1:0]   lb1_q [WIDTH_P];
  col_t            col_a_q, col_b_q, col_new;
  logic            mode_q;
  logic [MW-1:0]   thresh_q;

  logic            accept, slot_free, load_out, out_xfer;
  logic            in_first, in_last, out_border, out_last;
  logic [MW-1:0]   sum_xp, sum_xn, sum_yp, sum_yn, gx, gy, abs_gx, abs_gy, mag;
  logic [PW-1:0]   res;

  assign slot_free = !valid_o || ready_i;
  assign ready_o   = (state_q != FLUSH) && slot_free;
  assign accept    = valid_i && ready_o;
  assign out_xfer  = valid_o && ready_i;

  assign in_first   = (in_col_q == '0) && (in_row_q == '0);
  assign in_last    = (in_col_q == CW'(WIDTH_P-1)) && (in_row_q == RW'(HEIGHT_P-1));
  assign out_last   = (out_col_q == CW'(WIDTH_P-1)) && (out_row_q == RW'(HEIGHT_P-1));
  assign out_border = (out_col_q == '0) || (out_col_q == CW'(WIDTH_P-1)) ||
                      (out_row_q == '0) || (out_row_q == RW'(HEIGHT_P-1));

  // In FLUSH every remaining output lies on the bottom row or right column, so the window is not needed.
  assign load_out = ((state_q == RUN) && accept) ||
                    ((state_q == FLUSH) && slot_free && !(valid_o && last_o));

  // Window = two registered columns (c-2, c-1) plus the live column c built from the line buffers.
  assign col_new = '{top: lb1_q[in_col_q], mid: lb0_q[in_col_q], bot: pixel_i};

  always_comb begin
    sum_xp = MW'(col_new.top) + (MW'(col_new.mid) << 1) + MW'(col_new.bot);
    sum_xn = MW'(col_a_q.top) + (MW'(col_a_q.mid) << 1) + MW'(col_a_q.bot);
    sum_yp = MW'(col_a_q.bot) + (MW'(col_b_q.bot) << 1) + MW'(col_new.bot);
    sum_yn = MW'(col_a_q.top) + (MW'(col_b_q.top) << 1) + MW'(col_new.top);
    gx     = sum_xp - sum_xn;
    gy     = sum_yp - sum_yn;
    abs_gx = gx[MW-1] ? (MW'(0) - gx) : gx;
    abs_gy = gy[MW-1] ? (MW'(0) - gy) : gy;
    mag    = abs_gx + abs_gy;
    res    = '0;
    if (out_border) begin
      res = '0;
    end else if (mode_q) begin
      res = (mag >= thresh_q) ? '1 : '0;
    end else if (|mag[MW-1:PW]) begin
      res = '1;
    end else begin
      res = mag[PW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && (in_row_q == RW'(1)) && (in_col_q == '0)) state_d = RUN;
      RUN:     if (accept && in_last) state_d = FLUSH;
      FLUSH:   if (out_xfer && last_o) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= FILL;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      pixel_o   <= '0;
      mode_q    <= 1'b0;
      thresh_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (in_first) begin
          mode_q   <= mode_i;
          thresh_q <= thresh_i;
        end
        if (in_col_q == CW'(WIDTH_P-1)) begin
          in_col_q <= '0;
          in_row_q <= (in_row_q == RW'(HEIGHT_P-1)) ? '0 : in_row_q + RW'(1);
        end else begin
          in_col_q <= in_col_q + CW'(1);
        end
      end
      if (load_out) begin
        valid_o <= 1'b1;
        pixel_o <= res;
        last_o  <= out_last;
        if (out_col_q == CW'(WIDTH_P-1)) begin
          out_col_q <= '0;
          out_row_q <= (out_row_q == RW'(HEIGHT_P-1)) ? '0 : out_row_q + RW'(1);
        end else begin
          out_col_q <= out_col_q + CW'(1);
        end
      end else if (out_xfer) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_q[in_col_q] <= pixel_i;
      lb1_q[in_col_q] <= lb0_q[in_col_q];
      col_a_q         <= col_b_q;
      col_b_q         <= col_new;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed table of 4x4 frames, a 10-bit saturation build, a mid-frame reset, and random handshakes over 5x7 frames.
module tb_sobel_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic        a_valid_i, a_ready_o, a_mode_i, a_valid_o, a_ready_i, a_last_o;
  logic [7:0]  a_pixel_i, a_pixel_o;
  logic [10:0] a_thresh_i;
  logic        b_valid_i, b_ready_o, b_mode_i, b_valid_o, b_ready_i, b_last_o;
  logic [9:0]  b_pixel_i, b_pixel_o;
  logic [12:0] b_thresh_i;
  logic        c_valid_i, c_ready_o, c_mode_i, c_valid_o, c_ready_i, c_last_o;
  logic [7:0]  c_pixel_i, c_pixel_o;
  logic [10:0] c_thresh_i;

  sobel_stream #(.PIXEL_WIDTH_P(8), .WIDTH_P(4), .HEIGHT_P(4)) u_a (
    .clk_i(clk), .reset_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o), .pixel_i(a_pixel_i),
    .mode_i(a_mode_i), .thresh_i(a_thresh_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .pixel_o(a_pixel_o), .last_o(a_last_o));

  sobel_stream #(.PIXEL_WIDTH_P(10), .WIDTH_P(4), .HEIGHT_P(4)) u_b (
    .clk_i(clk), .reset_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o), .pixel_i(b_pixel_i),
    .mode_i(b_mode_i), .thresh_i(b_thresh_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .pixel_o(b_pixel_o), .last_o(b_last_o));

  sobel_stream #(.PIXEL_WIDTH_P(8), .WIDTH_P(5), .HEIGHT_P(7)) u_c (
    .clk_i(clk), .reset_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o), .pixel_i(c_pixel_i),
    .mode_i(c_mode_i), .thresh_i(c_thresh_i), .valid_o(c_valid_o), .ready_i(c_ready_i),
    .pixel_o(c_pixel_o), .last_o(c_last_o));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // v[] is the per-column value (or per-row when vert); e1/e2 are the interior results at index 1/2 along that axis.
  typedef struct packed {
    logic [3:0][7:0] v;
    logic            vert;
    logic            md;
    logic [10:0]     th;
    logic [7:0]      e1;
    logic [7:0]      e2;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(int v0, int v1, int v2, int v3, bit vert, bit md, int th, int e1, int e2);
    vec_t r;
    r.v[0] = 8'(v0); r.v[1] = 8'(v1); r.v[2] = 8'(v2); r.v[3] = 8'(v3);
    r.vert = vert; r.md = md; r.th = 11'(th); r.e1 = 8'(e1); r.e2 = 8'(e2);
    return r;
  endfunction

  logic [7:0] frame_a [16];
  int         got_px [16];
  int         got_last [16];
  int         got_rdy [16];

  task automatic build_a(input vec_t tv);
    for (int i = 0; i < 16; i++) frame_a[i] = tv.vert ? tv.v[i/4] : tv.v[i%4];
  endtask

  task automatic run_a(input bit md, input logic [10:0] th, input int t);
    int ni, no, cyc;
    ni = 0; no = 0; cyc = 0;
    while (no < 16 && cyc < 200) begin
      @(negedge clk);
      a_valid_i  = (ni < 16);
      a_pixel_i  = frame_a[(ni < 16) ? ni : 0];
      a_mode_i   = md;
      a_thresh_i = th;
      a_ready_i  = 1'b1;
      #1;
      if (a_valid_i && a_ready_o) ni++;
      if (a_valid_o && a_ready_i) begin
        got_px[no] = a_pixel_o; got_last[no] = a_last_o; got_rdy[no] = a_ready_o;
        no++;
      end
      cyc++;
    end
    a_valid_i = 1'b0;
    chk($sformatf("t%0d_outcount", t), no, 16);
  endtask

  task automatic cmp_a(input vec_t tv, input int t);
    for (int i = 0; i < 16; i++) begin
      int r, c, idx, e;
      r = i / 4; c = i % 4;
      idx = tv.vert ? r : c;
      e = (idx == 1) ? int'(tv.e1) : int'(tv.e2);
      if (r == 0 || r == 3 || c == 0 || c == 3) e = 0;
      chk($sformatf("t%0d_px%0d", t, i), got_px[i], e);
      chk($sformatf("t%0d_last%0d", t, i), got_last[i], (i == 15) ? 1 : 0);
      // Outputs 10..15 are presented while the block is in FLUSH.
      chk($sformatf("t%0d_rdy%0d", t, i), got_rdy[i], (i >= 10) ? 0 : 1);
    end
  endtask

  logic [7:0] in57 [105];
  int         md57 [3];
  int         th57 [3];

  function automatic int model57(int f, int r, int c);
    int p [9];
    int gx, gy, mag;
    if (r == 0 || r == 6 || c == 0 || c == 4) return 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        p[dr*3+dc] = int'(in57[f*35 + (r+dr-1)*5 + (c+dc-1)]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (md57[f] != 0) return (mag >= th57[f]) ? 255 : 0;
    return (mag > 255) ? 255 : mag;
  endfunction

  initial begin
    int nin, nout, cyc, lasts, hpx, hlast;
    bit hold;
    rst = 1'b1;
    a_valid_i = 0; a_pixel_i = 0; a_mode_i = 0; a_thresh_i = 0; a_ready_i = 1;
    b_valid_i = 0; b_pixel_i = 0; b_mode_i = 0; b_thresh_i = 0; b_ready_i = 1;
    c_valid_i = 0; c_pixel_i = 0; c_mode_i = 0; c_thresh_i = 0; c_ready_i = 0;

    tbl[0]  = mk(100, 100, 100, 100, 0, 0, 0,    0,   0);
    tbl[1]  = mk(0,   0,   10,  10,  0, 0, 0,    40,  40);
    tbl[2]  = mk(0,   0,   10,  10,  0, 1, 41,   0,   0);
    tbl[3]  = mk(0,   0,   10,  10,  0, 1, 40,   255, 255);
    tbl[4]  = mk(0,   0,   255, 255, 0, 0, 0,    255, 255);
    tbl[5]  = mk(100, 100, 100, 100, 0, 1, 0,    255, 255);
    tbl[6]  = mk(0,   0,   10,  10,  1, 0, 0,    40,  40);
    tbl[7]  = mk(5,   0,   20,  0,   0, 0, 0,    60,  0);
    tbl[8]  = mk(30,  20,  10,  0,   1, 0, 0,    80,  80);
    tbl[9]  = mk(5,   0,   20,  0,   1, 1, 60,   255, 0);
    tbl[10] = mk(0,   0,   255, 255, 0, 1, 1020, 255, 255);
    tbl[11] = mk(0,   0,   255, 255, 0, 1, 1021, 0,   0);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_a_valid", a_valid_o, 0);
    chk("reset_a_last", a_last_o, 0);
    chk("reset_a_pixel", a_pixel_o, 0);
    chk("reset_a_ready", a_ready_o, 1);
    chk("reset_c_valid", c_valid_o, 0);
    rst = 1'b0;

    for (int t = 0; t < 12; t++) begin
      build_a(tbl[t]);
      run_a(tbl[t].md, tbl[t].th, t);
      cmp_a(tbl[t], t);
    end

    // Reset mid-frame with output 1 pending, then the same frame again must reproduce exactly.
    build_a(tbl[1]);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_valid_i = 1'b1; a_pixel_i = frame_a[i]; a_ready_i = 1'b1; a_mode_i = 1'b0;
      #1;
      chk($sformatf("pre_rst_rdy%0d", i), a_ready_o, 1);
    end
    @(negedge clk);
    a_valid_i = 1'b0; a_ready_i = 1'b0;
    #1;
    chk("pre_rst_pending", a_valid_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", a_valid_o, 0);
    chk("post_rst_last", a_last_o, 0);
    chk("post_rst_pixel", a_pixel_o, 0);
    chk("post_rst_ready", a_ready_o, 1);
    run_a(1'b0, 11'd0, 100);
    cmp_a(tbl[1], 100);

    // 10-bit build: 0,0,1020-worth edge must not saturate.
    nin = 0; nout = 0; cyc = 0;
    while (nout < 16 && cyc < 200) begin
      @(negedge clk);
      b_valid_i = (nin < 16);
      b_pixel_i = ((nin % 4) < 2) ? 10'd0 : 10'd255;
      #1;
      if (b_valid_i && b_ready_o) nin++;
      if (b_valid_o && b_ready_i) begin
        int r, c;
        r = nout / 4; c = nout % 4;
        chk($sformatf("b_px%0d", nout), b_pixel_o,
            (r == 0 || r == 3 || c == 0 || c == 3) ? 0 : 1020);
        nout++;
      end
      cyc++;
    end
    b_valid_i = 1'b0;
    chk("b_outcount", nout, 16);

    // Three back-to-back 5x7 frames with random valid/ready and mode/thresh changing every cycle.
    for (int i = 0; i < 105; i++) in57[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) begin md57[i] = 0; th57[i] = 0; end
    nin = 0; nout = 0; cyc = 0; lasts = 0; hold = 0; hpx = 0; hlast = 0;
    while (nout < 105 && cyc < 4000) begin
      @(negedge clk);
      c_valid_i  = (nin < 105) && ($urandom_range(0, 1) == 1);
      c_pixel_i  = in57[(nin < 105) ? nin : 0];
      c_mode_i   = 1'($urandom_range(0, 1));
      c_thresh_i = 11'($urandom_range(0, 600));
      c_ready_i  = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        chk($sformatf("c_hold_valid%0d", nout), c_valid_o, 1);
        chk($sformatf("c_hold_px%0d", nout), c_pixel_o, hpx);
        chk($sformatf("c_hold_last%0d", nout), c_last_o, hlast);
      end
      if (c_valid_i && c_ready_o) begin
        if (nin % 35 == 0) begin
          md57[nin/35] = c_mode_i;
          th57[nin/35] = c_thresh_i;
        end
        nin++;
      end
      if (c_valid_o && c_ready_i) begin
        int f, k;
        f = nout / 35; k = nout % 35;
        chk($sformatf("c_px%0d", nout), c_pixel_o, model57(f, k / 5, k % 5));
        chk($sformatf("c_last%0d", nout), c_last_o, (k == 34) ? 1 : 0);
        if (c_last_o) lasts++;
        nout++;
      end
      hold = c_valid_o && !c_ready_i;
      hpx = c_pixel_o; hlast = c_last_o;
      cyc++;
    end
    chk("c_outcount", nout, 105);
    chk("c_incount", nin, 105);
    chk("c_lastcount", lasts, 3);
    c_valid_i = 1'b0; c_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("c_no_extra", c_valid_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
